// File: rtl/mcu_link_rx.sv
// mcu_link_rx
//
// Receiver for the two-wire sclk/data monitor link driven by the CEMF
// acquisition controller. Both link lines are oversampled with the system
// clock. Words are recovered MSB first, one bit per sclk rising edge, and
// buffered in a small FIFO that drains through a valid/ready port.
// Truncated words (idle timeout) and dropped words (FIFO full) raise sticky
// status flags.
//
// Optional feature macro: MCU_LINK_RX_PARITY_EN
//   When defined, each word is followed by one even-parity bit. A word with
//   bad parity is dropped and frame_err is set.
//
// Parameters
//   WORD_W       payload bits per word
//   FIFO_DEPTH   buffered words (power of two, >= 2)
//   IDLE_TIMEOUT clocks without an sclk edge before a partial word is dropped
//
// Ports
//   clock        system clock, single rising-edge domain
//   rst          synchronous active-high reset
//   mcu_sclk     link clock, asynchronous to clock
//   mcu_data     link data, asynchronous to clock
//   rx_data      head word of the FIFO (registered)
//   rx_valid     FIFO not empty
//   rx_ready     consumer pops the head word when rx_valid & rx_ready
//   frame_err    sticky: word truncated by timeout or bad parity
//   overflow     sticky: complete word dropped because the FIFO was full
//   clr_status   clears frame_err and overflow (wins over a same-cycle set)

`timescale 1ns/1ps

module mcu_link_rx #(
  parameter int WORD_W       = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              mcu_sclk,
  input  logic              mcu_data,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overflow,
  input  logic              clr_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef MCU_LINK_RX_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_PUSH   = 2'd3
  } state_t;

  // Synchronizers
  logic [2:0] sclk_s_q;
  logic [2:0] data_s_q;
  logic       sclkRise;
  logic       dataBit;
  logic       unused_data_tap;

  // Receive FSM
  state_t            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [IW-1:0]     idle_cnt_q;
  logic              frame_err_q;
  logic              overflow_q;
`ifdef MCU_LINK_RX_PARITY_EN
  logic              parity_q;
`endif
  logic              inShift;
  logic              timeoutHit;
  logic              parityOk;
  logic              pushReq;
  logic              frameErrSet;
  logic              overflowSet;

  // FIFO
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [AW:0]       rd_ptr_d;
  logic [WORD_W-1:0] rx_data_q;
  logic [WORD_W-1:0] rx_data_d;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              wrEn;
  logic              rdEn;

  // Three flops per line. The data bit is taken one stage earlier than the
  // edge decision so it is the value that was present when sclk rose.
  always_ff @(posedge clock) begin
    if (rst) begin
      sclk_s_q <= '0;
      data_s_q <= '0;
    end else begin
      sclk_s_q <= {sclk_s_q[1:0], mcu_sclk};
      data_s_q <= {data_s_q[1:0], mcu_data};
    end
  end

  assign sclkRise        = ~sclk_s_q[2] & sclk_s_q[1];
  assign dataBit         = data_s_q[1];
  assign unused_data_tap = data_s_q[2];

  // Timeout only matters while a word is partially received.
`ifdef MCU_LINK_RX_PARITY_EN
  assign inShift  = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
  // Even parity: payload XOR parity bit must be zero.
  assign parityOk = ((^shift_q) == parity_q);
`else
  assign inShift  = (state_q == ST_SHIFT);
  assign parityOk = 1'b1;
`endif

  assign timeoutHit  = inShift && !sclkRise && (idle_cnt_q == IDLE_MAX);
  assign pushReq     = (state_q == ST_PUSH) && parityOk;
  assign frameErrSet = timeoutHit || ((state_q == ST_PUSH) && !parityOk);
  assign overflowSet = pushReq && fifoFull;

  // Receive FSM, idle counter and sticky flags. A word is assembled in
  // shift_q; PUSH presents it to the FIFO for exactly one cycle. Bits shifted
  // in while IDLE push out stale contents, so no explicit clear is needed.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef MCU_LINK_RX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      if ((state_q == ST_IDLE) || sclkRise) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != IDLE_MAX) begin
        idle_cnt_q <= idle_cnt_q + IW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (sclkRise) begin
            shift_q   <= {shift_q[WORD_W-2:0], dataBit};
            bit_cnt_q <= BW'(1);
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclkRise) begin
            shift_q   <= {shift_q[WORD_W-2:0], dataBit};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == LAST_BIT) begin
`ifdef MCU_LINK_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_PUSH;
`endif
            end
          end else if (timeoutHit) begin
            state_q <= ST_IDLE;
          end
        end
`ifdef MCU_LINK_RX_PARITY_EN
        ST_PARITY: begin
          if (sclkRise) begin
            parity_q <= dataBit;
            state_q  <= ST_PUSH;
          end else if (timeoutHit) begin
            state_q <= ST_IDLE;
          end
        end
`endif
        ST_PUSH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (clr_status) begin
        frame_err_q <= 1'b0;
        overflow_q  <= 1'b0;
      end else begin
        if (frameErrSet) frame_err_q <= 1'b1;
        if (overflowSet) overflow_q  <= 1'b1;
      end
    end
  end

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal low
  // bits with differing wrap bits mean full. A full FIFO refuses a write even
  // when a pop happens in the same cycle.
  assign fifoEmpty = (wr_ptr_q == rd_ptr_q);
  assign fifoFull  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wrEn      = pushReq && !fifoFull;
  assign rdEn      = !fifoEmpty && rx_ready;
  assign rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rdEn};

  // rx_data is registered, so the next head is looked up one cycle early.
  // The only case where that slot is being written this cycle is when the
  // FIFO is (or becomes) empty, so the incoming word is forwarded instead.
  always_comb begin
    rx_data_d = mem_q[rd_ptr_d[AW-1:0]];
    if (wrEn && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      rx_data_d = shift_q;
    end
  end

  // Storage array is not reset; only the pointers define its contents.
  always_ff @(posedge clock) begin
    if (!rst && wrEn) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  // Pointer and head-register update.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rx_data_q <= '0;
    end else begin
      if (wrEn) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      rd_ptr_q  <= rd_ptr_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = !fifoEmpty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mcu_link_rx.sv
// tb_mcu_link_rx
//
// Drives the sclk/data link with 4-clock high and low phases and tracks the
// words expected on the rx port in a queue. A monitor pops the queue on every
// handshake; scenario tasks check flags, latency and FIFO behaviour inline.

`timescale 1ns/1ps

module tb_mcu_link_rx;

  logic        clock      = 1'b0;
  logic        rst        = 1'b1;
  logic        mcu_sclk   = 1'b0;
  logic        mcu_data   = 1'b0;
  logic        rx_ready   = 1'b0;
  logic        clr_status = 1'b0;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] monExp;

  always #5 clock = ~clock;

  mcu_link_rx #(
    .WORD_W      (32),
    .FIFO_DEPTH  (4),
    .IDLE_TIMEOUT(255)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .mcu_sclk  (mcu_sclk),
    .mcu_data  (mcu_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clr_status(clr_status)
  );

  // Scoreboard monitor: samples late in the low phase, just before the
  // rising edge on which the DUT performs the pop.
  always @(negedge clock) begin
    #3;
    if (!rst && rx_valid && rx_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_word: got %h, required no word", rx_data);
      end else begin
        monExp = expQ.pop_front();
        if (rx_data !== monExp) begin
          errors++;
          $display("[TB] FAIL word_order: got %h, required %h", rx_data, monExp);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendBit(input logic b);
    @(negedge clock);
    mcu_data = b;
    repeat (4) @(negedge clock);
    mcu_sclk = 1'b1;
    repeat (4) @(negedge clock);
    mcu_sclk = 1'b0;
  endtask

  // Sends every edge of a word except the final one and returns the bit the
  // final edge must carry (bit 0, or the even parity bit).
  task automatic sendPrefix(input logic [31:0] w, output logic finalBit);
`ifdef MCU_LINK_RX_PARITY_EN
    for (int i = 31; i >= 0; i--) sendBit(w[i]);
    finalBit = ^w;
`else
    for (int i = 31; i >= 1; i--) sendBit(w[i]);
    finalBit = w[0];
`endif
  endtask

  task automatic raiseFinal(input logic b);
    @(negedge clock);
    mcu_data = b;
    repeat (4) @(negedge clock);
    mcu_sclk = 1'b1;
  endtask

  task automatic sendWord(input logic [31:0] w, input logic flipFinal);
    logic fb;
    sendPrefix(w, fb);
    raiseFinal(fb ^ flipFinal);
    repeat (4) @(negedge clock);
    mcu_sclk = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clock);
    clr_status = 1'b1;
    @(negedge clock);
    clr_status = 1'b0;
    @(negedge clock);
  endtask

  task automatic drainQueue();
    rx_ready = 1'b1;
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", rx_valid); end
    checks++;
    if (rx_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h, required 0", rx_data); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b, required 0", frame_err); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_single();
    logic fb;
    int   firstSeen;
    int   validCycles;
    firstSeen   = 0;
    validCycles = 0;
    rx_ready    = 1'b1;
    expQ.push_back(32'hA5C3_0F01);
    sendPrefix(32'hA5C3_0F01, fb);
    raiseFinal(fb);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (rx_valid === 1'b1) begin
        validCycles++;
        if (firstSeen == 0) firstSeen = k;
      end
    end
    mcu_sclk = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (firstSeen != 4) begin errors++; $display("[TB] FAIL single_latency: got %0d, required 4", firstSeen); end
    checks++;
    if (validCycles != 1) begin errors++; $display("[TB] FAIL single_pulse: got %0d cycles, required 1", validCycles); end
    checks++;
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL single_missing: got %0d pending, required 0", expQ.size()); end
    checks++;
    if ({frame_err, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL single_flags: got %b, required 00", {frame_err, overflow}); end
  endtask

  task automatic test_overflow();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expQ.push_back(32'(i));
      sendWord(32'(i), 1'b0);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b, required 1", overflow); end
    checks++;
    if (rx_data !== 32'h1) begin errors++; $display("[TB] FAIL ovf_head_stable: got %h, required 1", rx_data); end
    drainQueue();
    checks++;
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL ovf_missing: got %0d pending, required 0", expQ.size()); end
    pulseClear();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b, required 0", overflow); end
  endtask

  task automatic test_frame_err();
    logic [31:0] partial;
    partial  = 32'h1234_5678;
    rx_ready = 1'b1;
    for (int i = 31; i >= 12; i--) sendBit(partial[i]);
    repeat (300) @(negedge clock);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: got %b, required 1", frame_err); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_no_word: got %b, required 0", rx_valid); end
    expQ.push_back(32'hDEAD_BEEF);
    sendWord(32'hDEAD_BEEF, 1'b0);
    drainQueue();
    checks++;
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL timeout_missing: got %0d pending, required 0", expQ.size()); end
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b, required 1", frame_err); end
    pulseClear();
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %b, required 0", frame_err); end
  endtask

  task automatic test_reset_midword();
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) sendBit(i[0]);
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b, required 0", rx_valid); end
    expQ.push_back(32'h0000_FFFF);
    sendWord(32'h0000_FFFF, 1'b0);
    drainQueue();
    checks++;
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL midrst_missing: got %0d pending, required 0", expQ.size()); end
    checks++;
    if ({frame_err, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_flags: got %b, required 00", {frame_err, overflow}); end
  endtask

  // Raises the final edge of a word and pops exactly in the PUSH cycle:
  // edge is seen 2 clocks after sclk rises, PUSH is the clock after that.
  task automatic pushWithPop(input logic [31:0] w);
    logic fb;
    sendPrefix(w, fb);
    raiseFinal(fb);
    repeat (3) @(negedge clock);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [8];
    words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
              32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(words[i]);
      sendWord(words[i], 1'b0);
    end
    expQ.push_back(words[3]);
    pushWithPop(words[3]);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL pp3_valid: got %b, required 1", rx_valid); end
    checks++;
    if (rx_data !== words[1]) begin errors++; $display("[TB] FAIL pp3_head: got %h, required %h", rx_data, words[1]); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pp3_overflow: got %b, required 0", overflow); end
    @(negedge clock);
    mcu_sclk = 1'b0;
    drainQueue();
    checks++;
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL pp3_missing: got %0d pending, required 0", expQ.size()); end

    rx_ready = 1'b0;
    for (int i = 4; i < 8; i++) begin
      expQ.push_back(words[i]);
      sendWord(words[i], 1'b0);
    end
    pushWithPop(32'h9999_0009);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ppfull_overflow: got %b, required 1", overflow); end
    checks++;
    if (rx_data !== words[5]) begin errors++; $display("[TB] FAIL ppfull_head: got %h, required %h", rx_data, words[5]); end
    @(negedge clock);
    mcu_sclk = 1'b0;
    drainQueue();
    checks++;
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL ppfull_missing: got %0d pending, required 0", expQ.size()); end
    pulseClear();
  endtask

`ifdef MCU_LINK_RX_PARITY_EN
  task automatic test_parity();
    rx_ready = 1'b1;
    expQ.push_back(32'h0000_0001);
    sendWord(32'h0000_0001, 1'b0);
    drainQueue();
    checks++;
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL parity_good_missing: got %0d pending, required 0", expQ.size()); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL parity_good_flag: got %b, required 0", frame_err); end
    sendWord(32'h0000_0001, 1'b1);
    repeat (6) @(negedge clock);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad_flag: got %b, required 1", frame_err); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL parity_bad_dropped: got %b, required 0", rx_valid); end
    pulseClear();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_frame_err();
    test_reset_midword();
    test_back_to_back();
`ifdef MCU_LINK_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_link_rx.md
# mcu_link_rx

Receiver for the two-wire serial monitor link (`mcu_sclk`/`mcu_data`) that the CEMF acquisition controller drives toward the MCU. It oversamples both lines with the system clock, recovers 32-bit words, and buffers them in a small FIFO with a valid/ready output. It is used on the MCU-side FPGA and as the checker endpoint in loopback benches. It also flags truncated words and FIFO overflow.

## Interface
Parameters:
- `WORD_W`, 32, payload bits per word.
- `FIFO_DEPTH`, 4, number of buffered words; must be a power of two, minimum 2.
- `IDLE_TIMEOUT`, 255, system clocks without an sclk rising edge before the bit counter resets.

Ports:
- `clock` input 1: system clock. One clock domain only; all logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `mcu_sclk` input 1: link clock, asynchronous to `clock`.
- `mcu_data` input 1: link data, asynchronous to `clock`.
- `rx_data` output WORD_W: head word of the FIFO.
- `rx_valid` output 1: FIFO not empty.
- `rx_ready` input 1: consumer pops the head word when `rx_valid & rx_ready`.
- `frame_err` output 1: sticky flag; a word was truncated by idle timeout, or had a parity error (parity only with the macro).
- `overflow` output 1: sticky flag; a complete word was dropped because the FIFO was full.
- `clr_status` input 1: clears `frame_err` and `overflow`.

## Operation
- Synchronizer: 3-stage shift register per line (`s[0]`, `s[1]`, `s[2]`). A rising sclk edge is the condition `sclk_s[2]==0 && sclk_s[1]==1`. The data bit is taken from `data_s[1]` in the same cycle.
- Bit order: MSB first. Each word occupies exactly WORD_W rising edges.
- FSM states:
  - IDLE → SHIFT on the first edge, which loads bit[WORD_W-1].
  - SHIFT:
    - Each edge shifts in one bit.
    - After the last bit, the FSM goes to PUSH, or to PARITY with the macro.
    - If the idle counter reaches IDLE_TIMEOUT, the FSM goes to IDLE, discards the partial word, and sets `frame_err`.
  - PARITY: the next edge captures the parity bit, then the FSM goes to PUSH. Idle timeout applies as in SHIFT.
  - PUSH: lasts one cycle.
    - FIFO not full: the word is written.
    - FIFO full: the word is dropped and `overflow` is set.
    - The FSM then returns to IDLE.
- Idle counter: cleared on every sclk edge and in IDLE. It saturates at IDLE_TIMEOUT.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are derived from the MSB and the remaining pointer bits.
  - A write and a read in the same cycle are both performed.
  - When the FIFO is full, the write is still refused even if a pop happens in the same cycle.
- `rx_data` is the registered memory entry at the read pointer. It is stable while `rx_valid` is high and `rx_ready` is low.
- `clr_status` has priority over a set event in the same cycle.
- Reset values: FSM in IDLE, pointers 0, `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overflow`=0, synchronizers 0.
- Reset asserted mid-word discards the partial word and the FIFO contents.

## Timing
- Edge detect fires 2 clocks after `mcu_sclk` rises at `s[0]`'s input; this is the synchronizer latency.
- Last bit edge to `rx_valid` high, with the FIFO initially empty: 2 clocks (edge cycle → PUSH → visible).
- Pop to next head word on `rx_data`: the cycle after the handshake.
- Minimum supported sclk high and low time: 3 `clock` periods each. Faster input is out of spec.
- Word-to-word gap: none required. The edge following PUSH may start the next word, provided PUSH does not coincide with an edge. The sclk timing above guarantees this.

## Configuration
- `MCU_LINK_RX_PARITY_EN`
  - Defined: each word is followed by one extra bit giving even parity over the WORD_W payload bits.
  - On a parity mismatch the word is dropped (not written) and `frame_err` is set.
  - Undefined: the PARITY state and the check are absent, and a word is exactly WORD_W edges.

## Test plan
- Send 0xA5C3_0F01 with `rx_ready`=1 → `rx_valid` pulses for 1 cycle with `rx_data`=0xA5C3_0F01. No flags set.
- Send 5 words (0x1..0x5) with `rx_ready`=0, then release → words 0x1..0x4 popped in order, `overflow`=1. Then pulse `clr_status` → `overflow`=0.
- Send 20 bits, idle 300 clocks, then send full word 0xDEAD_BEEF → `frame_err`=1 and only 0xDEAD_BEEF received.
- Assert `rst` after 16 bits of a word, then send 0x0000_FFFF → only 0x0000_FFFF received; all flags 0.
- FIFO at 3 entries, pop and push in the same cycle → count stays 3 and order is preserved. FIFO full with pop and push in the same cycle → word dropped, `overflow`=1.
- Macro defined: send 0x0000_0001 with parity bit 1 → accepted. Send it with parity bit 0 → not written, `frame_err`=1.
